mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  - Shares one combinational 4x4 unsigned Multiplier between NREQ requesters.
//  - Each requester uses a valid/ready handshake on request and response.
//  - Round-robin grant; one transaction in flight at a time.
//  - The block sits between the client FSMs and the single Multiplier instance.
// PARAMETERS
//  NREQ  default 2  number of requesters, 2..4
//  W     default 4  operand width; product is 2*W bits
// PORTS
//  CLK        in   1         clock; all state updates on posedge
//  rst_n      in   1         reset, asynchronous, active-low
//  req_valid  in   NREQ      per-requester request strobe
//  req_a      in   NREQ*W    packed operand a; slice i belongs to requester i
//  req_b      in   NREQ*W    packed operand b
//  req_ready  out  NREQ      one-hot; high when requester i's request is accepted this cycle
//  resp_valid out  NREQ      one-hot; product ready for requester i
//  resp_p     out  2*W       product, shared bus, meaningful only while resp_valid != 0
//  resp_ready in   NREQ      per-requester response accept
//  busy       out  1         high when state != IDLE
// BEHAVIOUR
//  - Reset values: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_p=0, busy=0.
//  - FSM has three states:
//    - IDLE: req_ready is combinational. When any req_valid is set, grant goes to the first
//      requester at or after rr_ptr (modulo NREQ). Only that requester sees req_ready=1.
//      On the edge, a_q/b_q/gnt_q latch its operands, rr_ptr <= gnt+1 mod NREQ, and the
//      FSM moves to CALC.
//    - CALC: a_q/b_q drive the Multiplier. On the edge, resp_p <= p, the FSM moves to RESP,
//      and resp_valid[gnt_q] <= 1.
//    - RESP: hold resp_p and resp_valid. When resp_ready[gnt_q]=1, clear resp_valid and
//      return to IDLE. The next request is accepted no earlier than the following cycle.
//  - Latency: 2 edges from acceptance to resp_valid. Minimum 3 cycles per transaction.
//  - resp_ready bits of non-granted requesters are ignored.
//  - The request handshake completes in the cycle where req_valid & req_ready.
//    Requesters must hold operands stable until then.
//  - Arithmetic: unsigned; p = a*b exactly, 2*W bits, no truncation (15*15=225 fits 8 bits).
//  - Fairness: with all requesters continuously valid, the grant order is 0,1,..,NREQ-1,0,...
//  - Single requester: it is granted every transaction regardless of rr_ptr.
//  - Reset asserted mid-transaction aborts it: all outputs drop to reset values
//    immediately (async), and the pending result is discarded.
// CONFIGURATION
//  - Macro MULT_SELFCHECK_EN.
//  - When defined: adds output err (1 bit, reset 0). In CALC, err <= (p != a_q*b_q)
//    computed behaviourally. err is sticky until reset.
//  - When undefined: err port and checker are absent, with no other change.
// STRUCTURE
//  - Package mult_share_pkg holds:
//    - state localparams S_IDLE=2'd0, S_CALC=2'd1, S_RESP=2'd2;
//    - function rr_pick(valid, ptr) returning the grant index.
//  - Sub-module: the existing combinational Multiplier (a, b -> p), instantiated once.
//    Arbitration, FSM and operand/result registers live in this module.
// TESTING
//  1. Reset, then req_valid=01 with a0=3, b0=5
//     -> req_ready=01 that cycle; resp_valid=01 and resp_p=15 two edges later.
//  2. Exhaustive single requester: all 256 {a,b} pairs through port 0
//     -> each resp_p == a*b, including 15*15=225 and 0*x=0.
//  3. Both requesters held valid (a0=2,b0=3; a1=4,b1=5), resp_ready=11
//     -> grants alternate 0,1,0,1; products 6 and 20 go to the matching resp_valid bit.
//  4. Backpressure: hold resp_ready=0 for 5 cycles in RESP
//     -> resp_valid and resp_p are stable, req_ready=00, busy=1.
//     Then assert resp_ready -> IDLE next cycle.
//  5. Assert rst_n=0 during CALC
//     -> resp_valid=0, busy=0 immediately.
//     After release, a new request completes normally with rr_ptr=0.
//  6. With MULT_SELFCHECK_EN: run test 2 -> err stays 0.
//     Force the Multiplier p output wrong -> err=1 and stays set.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// Build option: MULT_SELFCHECK_EN (adds a sticky product self-check in the top).
package mult_share_pkg;

  // Widest supported requester count and the index width that covers it.
  localparam int unsigned MaxReq = 4;
  localparam int unsigned IdxW   = 2;

  // Transaction FSM states; encodings are fixed so they can be read off a waveform.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Round-robin pick: first requester at or after ptr (modulo nreq) with its valid set.
  // Scans from the farthest offset to the nearest so the nearest hit wins.
  // Returns ptr when nothing is valid; callers only use the result when |valid.
  function automatic logic [IdxW-1:0] rr_pick(input logic [MaxReq-1:0] valid,
                                              input logic [IdxW-1:0]   ptr,
                                              input int unsigned       nreq);
    logic [IdxW-1:0] pick;
    logic [IdxW-1:0] sel;
    int unsigned     off;
    int unsigned     sum;
    pick = ptr;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      off = MaxReq - 1 - k;
      if (off < nreq) begin
        sum = {30'b0, ptr} + off;
        if (sum >= nreq) begin
          sum = sum - nreq;
        end
        sel = sum[IdxW-1:0];
        if (valid[sel]) begin
          pick = sel;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_mult.sv
// Combinational unsigned W x W multiplier producing the full 2*W-bit product.
module mult_share_arbiter_mult #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  // Zero-extend both operands first so the product is never truncated.
  assign p_o = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one combinational multiplier between NREQ valid/ready requesters.
// Round-robin grant, one transaction in flight: IDLE -> CALC -> RESP -> IDLE.
// Build option: MULT_SELFCHECK_EN adds a sticky err output that flags any
// cycle where the multiplier disagrees with a behavioural product in CALC.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 4
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [2*W-1:0]    resp_p,
  input  logic [NREQ-1:0]   resp_ready,
  output logic              busy
`ifdef MULT_SELFCHECK_EN
  ,
  output logic              err
`endif
);

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [2*W-1:0]  resp_p_q, resp_p_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;

  logic [MaxReq-1:0] valid_ext;
  logic [IdxW-1:0]   pick;
  logic [W-1:0]      pick_a;
  logic [W-1:0]      pick_b;
  logic [2*W-1:0]    p;
  logic              resp_taken;

  assign valid_ext = MaxReq'(req_valid);
  assign pick      = rr_pick(valid_ext, rr_q, NREQ);

  // Only the granted requester's response bit is set in RESP, so masking
  // resp_ready with resp_valid_q ignores every non-granted requester.
  assign resp_taken = |(resp_ready & resp_valid_q);

  // Operand mux for the requester the round-robin pick selects.
  always_comb begin
    pick_a = req_a[W*int'(pick) +: W];
    pick_b = req_b[W*int'(pick) +: W];
  end

  mult_share_arbiter_mult #(
    .W (W)
  ) u_mult (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (p)
  );

  // Next-state, grant and register-load decisions for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gnt_d        = gnt_q;
    a_d          = a_q;
    b_d          = b_q;
    resp_p_d     = resp_p_q;
    resp_valid_d = resp_valid_q;
    req_ready    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready = NREQ'(1) << pick;
          gnt_d     = pick;
          a_d       = pick_a;
          b_d       = pick_b;
          if (pick == IdxW'(NREQ - 1)) begin
            rr_d = '0;
          end else begin
            rr_d = pick + 1'b1;
          end
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        resp_p_d     = p;
        resp_valid_d = NREQ'(1) << gnt_q;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_taken) begin
          resp_valid_d = '0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        resp_valid_d = '0;
        state_d      = S_IDLE;
      end
    endcase
  end

  // State, pointer, operand and result registers; reset aborts any transaction.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      gnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      resp_p_q     <= '0;
      resp_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      resp_p_q     <= resp_p_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_p     = resp_p_q;
  assign busy       = (state_q != S_IDLE);

`ifdef MULT_SELFCHECK_EN
  logic           err_q, err_d;
  logic [2*W-1:0] p_ref;

  assign p_ref = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};

  // Sticky flag: set when the shared multiplier disagrees with the reference in CALC.
  always_comb begin
    err_d = err_q;
    if ((state_q == S_CALC) && (p != p_ref)) begin
      err_d = 1'b1;
    end
  end

  // Error register; only reset clears it.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a transaction-level model.
// Build option: MULT_SELFCHECK_EN enables the err-port checks.
module tb_mult_share_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 4;

  logic                CLK = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*W-1:0]   req_a = '0;
  logic [NREQ*W-1:0]   req_b = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     resp_valid;
  logic [2*W-1:0]      resp_p;
  logic [NREQ-1:0]     resp_ready = '0;
  logic                busy;
`ifdef MULT_SELFCHECK_EN
  logic                err;
`endif

  always #5 CLK = ~CLK;

  mult_share_arbiter #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_p     (resp_p),
    .resp_ready (resp_ready),
    .busy       (busy)
`ifdef MULT_SELFCHECK_EN
    ,
    .err        (err)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: m_age < 0 means no transaction, otherwise edges since acceptance
  // (saturating at 1 = result presented).
  int m_rr    = 0;
  int m_owner = 0;
  int m_prod  = 0;
  int m_age   = -1;
  bit skip_p  = 1'b0;
  bit forcing = 1'b0;
  bit m_err   = 1'b0;

  // Compare DUT against the model on every falling edge, then advance the model
  // to what the next rising edge must produce.
  always @(negedge CLK) begin : model_cmp
    int g;
    int c;
    int ea;
    int eb;
    if (!rst_n) begin
      check("rst_busy", busy, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_p", resp_p, 0);
      m_rr  = 0;
      m_age = -1;
      m_err = 1'b0;
`ifdef MULT_SELFCHECK_EN
      check("rst_err", err, 0);
`endif
    end else begin
      g = -1;
      if (m_age < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          c = (m_rr + k) % NREQ;
          if (g < 0 && req_valid[c]) g = c;
        end
      end
      check("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
      check("busy", busy, (m_age >= 0) ? 1 : 0);
      check("resp_valid", resp_valid, (m_age >= 1) ? (1 << m_owner) : 0);
      if (m_age >= 1 && !skip_p) check("resp_p", resp_p, m_prod);
`ifdef MULT_SELFCHECK_EN
      check("err", err, m_err);
`endif
      if (m_age < 0) begin
        if (g >= 0) begin
          ea      = int'(req_a[g*W +: W]);
          eb      = int'(req_b[g*W +: W]);
          m_owner = g;
          m_prod  = ea * eb;
          m_rr    = (g + 1) % NREQ;
          m_age   = 0;
        end
      end else if (m_age == 0) begin
        m_age = 1;
        if (forcing) m_err = 1'b1;
      end else if (resp_ready[m_owner]) begin
        m_age = -1;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    @(negedge CLK);
    @(negedge CLK);
    #1 rst_n = 1'b1;
    tick();
  endtask

  // Requesters in en_mask issue target transactions in total; exhaustive mode walks
  // all {a,b} pairs on requester 0, otherwise operands and raise timing are random.
  task automatic traffic(input logic [NREQ-1:0] en_mask, input int target, input bit exhaustive);
    int issued   = 0;
    int accepted = 0;
    int cyc      = 0;
    logic [NREQ-1:0] acc;
    while (cyc < 20000) begin
      @(negedge CLK);
      acc = req_valid & req_ready;
      if (accepted + $countones(acc) >= target && !busy && acc == '0 && req_valid == '0) break;
      tick();
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          req_valid[i] = 1'b0;
          accepted++;
        end else if (!req_valid[i] && en_mask[i] && issued < target) begin
          if (exhaustive) begin
            req_a[i*W +: W] = 4'(issued / 16);
            req_b[i*W +: W] = 4'(issued % 16);
            req_valid[i]    = 1'b1;
            issued++;
          end else if ($urandom_range(0, 2) != 0) begin
            req_a[i*W +: W] = 4'($urandom_range(0, 15));
            req_b[i*W +: W] = 4'($urandom_range(0, 15));
            req_valid[i]    = 1'b1;
            issued++;
          end
        end
      end
      resp_ready = exhaustive ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
    end
    check("traffic_done", accepted, target);
    resp_ready = '0;
  endtask

  int grants[8];
  int r_owner[8];
  int r_prod[8];
  int n_g;
  int n_r;

  initial begin
    do_reset();

    // Single request from port 0: ready this cycle, result two edges after acceptance.
    req_valid = 2'b01;
    req_a     = {4'd0, 4'd3};
    req_b     = {4'd0, 4'd5};
    @(negedge CLK);
    check("t1_req_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    tick();
    check("t1_resp_valid", resp_valid, 2'b01);
    check("t1_resp_p", resp_p, 15);
    resp_ready = 2'b01;
    tick();
    check("t1_idle", busy, 0);
    resp_ready = '0;

    // Both requesters held valid: grants alternate and products follow the owner.
    do_reset();
    req_a      = {4'd4, 4'd2};
    req_b      = {4'd5, 4'd3};
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    n_g = 0;
    n_r = 0;
    repeat (14) begin
      @(negedge CLK);
      if (req_ready != '0 && n_g < 8) begin
        grants[n_g] = (req_ready == 2'b10) ? 1 : 0;
        n_g++;
      end
      if (resp_valid != '0 && n_r < 8) begin
        r_owner[n_r] = (resp_valid == 2'b10) ? 1 : 0;
        r_prod[n_r]  = int'(resp_p);
        n_r++;
      end
      tick();
    end
    req_valid = '0;
    repeat (4) tick();
    resp_ready = '0;
    check("t3_grant_count_ge4", (n_g >= 4) ? 1 : 0, 1);
    check("t3_grant0", grants[0], 0);
    check("t3_grant1", grants[1], 1);
    check("t3_grant2", grants[2], 0);
    check("t3_grant3", grants[3], 1);
    check("t3_resp0_owner", r_owner[0], 0);
    check("t3_resp0_p", r_prod[0], 6);
    check("t3_resp1_owner", r_owner[1], 1);
    check("t3_resp1_p", r_prod[1], 20);

    // Backpressure: result held five cycles, nobody else accepted meanwhile.
    req_valid = 2'b01;
    req_a     = {4'd1, 4'd7};
    req_b     = {4'd1, 4'd9};
    tick();
    req_valid = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("t4_resp_valid", resp_valid, 2'b01);
      check("t4_resp_p", resp_p, 63);
      check("t4_req_ready", req_ready, 2'b00);
      check("t4_busy", busy, 1);
      tick();
    end
    resp_ready = 2'b01;
    tick();
    check("t4_back_idle", busy, 0);
    check("t4_next_ready", req_ready, 2'b10);
    resp_ready = 2'b11;
    tick();
    req_valid = '0;
    repeat (3) tick();
    resp_ready = '0;

    // Reset during CALC aborts the transaction at once.
    do_reset();
    req_valid = 2'b01;
    req_a     = {4'd0, 4'd6};
    req_b     = {4'd0, 4'd7};
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    check("t5_abort_resp_valid", resp_valid, 0);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_req_ready", req_ready, 0);
    @(negedge CLK);
    @(negedge CLK);
    #1 rst_n = 1'b1;
    tick();
    req_valid = 2'b11;
    req_a     = {4'd3, 4'd2};
    req_b     = {4'd3, 4'd2};
    @(negedge CLK);
    check("t5_rr_restart", req_ready, 2'b01);
    tick();
    req_valid  = '0;
    resp_ready = 2'b11;
    tick();
    check("t5_resp_p", resp_p, 4);
    repeat (2) tick();
    resp_ready = '0;

    // Exhaustive operands on requester 0, then random two-requester traffic.
    do_reset();
    traffic(2'b01, 256, 1'b1);
    traffic(2'b11, 150, 1'b0);
    traffic(2'b10, 20, 1'b0);

`ifdef MULT_SELFCHECK_EN
    // Corrupt the shared multiplier: err must rise and stay set after release.
    force dut.u_mult.p_o = 8'hFF;
    forcing = 1'b1;
    skip_p  = 1'b1;
    traffic(2'b01, 1, 1'b0);
    release dut.u_mult.p_o;
    forcing = 1'b0;
    skip_p  = 1'b0;
    traffic(2'b11, 4, 1'b0);
    @(negedge CLK);
    check("t6_err_sticky", err, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
